// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Holds the FSM state encoding and counter sizing.
package serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_hold_buf.sv
// One-entry word buffer that lets the next frame queue
// while the current one is still shifting out.
module serial_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (rd_en) full_d = 1'b0;
        if (wr_en) begin
            data_d = din;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter with a one-word hold
// buffer so consecutive frames stream without idle bits.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             Data_out,
    output logic             out_valid,
    output logic             frame_last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_dout;
    logic             hold_wr;
    logic             hold_rd;
    logic             accept;
    logic [WIDTH-1:0] sh_next;

    assign in_ready = !hold_full && !rst;
    assign accept   = in_valid && in_ready;

    // Vacated position always fills with 0.
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        hold_wr = 1'b0;
        hold_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = par_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    if (hold_full) begin
                        sh_d    = hold_dout;
                        hold_rd = 1'b1;
                        cnt_d   = '0;
                    end else if (accept) begin
                        sh_d  = par_in;
                        cnt_d = '0;
                    end else begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sh_d    = sh_next;
                    cnt_d   = cnt_q + CW'(1);
                    hold_wr = accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr_en (hold_wr),
        .rd_en (hold_rd),
        .din   (par_in),
        .full  (hold_full),
        .dout  (hold_dout)
    );

    assign out_valid  = (state_q == SHIFT);
    assign frame_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign Data_out   = (state_q == SHIFT) &&
                        (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: MSB-first and LSB-first transmitters share stimulus
// and are compared bit by bit against a queue-based reference model.
module tb_serial_frame_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] par_in;
    logic         in_valid;

    logic rdy_m, d_m, ov_m, fl_m;
    logic rdy_l, d_l, ov_l, fl_l;

    int errors = 0;
    int checks = 0;

    // Each entry is {expected bit, expected frame_last}.
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .par_in(par_in), .in_valid(in_valid),
        .in_ready(rdy_m), .Data_out(d_m), .out_valid(ov_m),
        .frame_last(fl_m)
    );

    serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .par_in(par_in), .in_valid(in_valid),
        .in_ready(rdy_l), .Data_out(d_l), .out_valid(ov_l),
        .frame_last(fl_l)
    );

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // A word accepted at this edge contributes W bits to each stream.
    always @(posedge clk) begin
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (in_valid && rdy_m)
                for (int i = 0; i < W; i++)
                    qm.push_back({par_in[W-1-i], i == W - 1});
            if (in_valid && rdy_l)
                for (int i = 0; i < W; i++)
                    ql.push_back({par_in[i], i == W - 1});
        end
    end

    task automatic mon(input string nm, input logic ov, input logic d,
                       input logic fl, input logic rdy, input int qs,
                       input logic [1:0] head, output logic pop);
        pop = 1'b0;
        // Words accepted but not yet started occupy the hold buffer.
        chk({nm, " in_ready"}, rdy, !rst && (qs <= W));
        if (ov) begin
            if (qs == 0) begin
                chk({nm, " spurious out_valid"}, ov, 1'b0);
            end else begin
                chk({nm, " Data_out"}, d, head[1]);
                chk({nm, " frame_last"}, fl, head[0]);
                pop = 1'b1;
            end
        end else begin
            chk({nm, " out_valid gap"}, ov, qs != 0);
            chk({nm, " idle Data_out"}, d, 1'b0);
            chk({nm, " idle frame_last"}, fl, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        logic pm, pl;
        mon("msb", ov_m, d_m, fl_m, rdy_m, qm.size(),
            qm.size() > 0 ? qm[0] : 2'b00, pm);
        if (pm) void'(qm.pop_front());
        mon("lsb", ov_l, d_l, fl_l, rdy_l, ql.size(),
            ql.size() > 0 ? ql[0] : 2'b00, pl);
        if (pl) void'(ql.pop_front());
    end

    task automatic send(input logic [W-1:0] w);
        logic acc;
        acc = 1'b0;
        par_in   = w;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(posedge clk);
            acc = rdy_m;
            #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send timeout: got no accept required accept");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((qm.size() != 0 || ql.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain timeout: got %0d bits left required 0",
                     qm.size());
        end
        idle(2);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        par_in   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        send(4'b1011);
        drain();

        send(4'b1011);
        send(4'b0110);
        drain();

        send(4'b1011);
        send(4'b0110);
        send(4'b1001);
        drain();

        // Reset lands while the second bit is on the line.
        send(4'b1011);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        send(4'b1101);
        drain();

        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 99) < 2);
            in_valid = ($urandom_range(0, 9) < 6);
            par_in   = W'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        for (int k = 0; k < 12; k++)
            send(W'($urandom));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
